// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl: record/playback controller for the off-chip audio SRAM.
// One word is moved per accepted i_start: record (write at ptr), forward play
// (read at ptr, advance by 1+step up to the recorded length) or reverse play
// (read at ptr-1, retreat by 1+step down to 0). Refused requests pulse o_fin.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           pointer re-init (priority over i_start)
//   i_mode            0 fwd play, 1 record, 2 reverse play, 3 reserved
//   i_step            extra words skipped per play access
//   i_start           access request, honoured in idle only
//   i_w_data          record sample, captured on acceptance
//   o_busy            access in progress
//   o_valid           write done / o_r_data updated (1-cycle pulse)
//   o_fin             request refused (1-cycle pulse)
//   o_r_data          last word read, held between reads
//   o_length          number of words recorded
//   o_SRAM_*          SRAM address, data and active-low strobes
module sram_stream_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STEP_W  = 3,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [1:0]        i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_fin,
  output logic [DATA_W-1:0] o_r_data,
  output logic [ADDR_W:0]   o_length,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DONE, S_FIN} state_t;
  typedef enum logic [1:0] {M_FWD = 2'd0, M_REC = 2'd1, M_REV = 2'd2, M_RSV = 2'd3} mode_t;

  state_t              state, state_n;
  mode_t               mode_in, mode_q;
  logic [STEP_W-1:0]   step_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   r_data;
  logic [PW-1:0]       ptr, ptr_n, len, len_n;
  logic [PW-1:0]       rev_m1;
  logic [PW:0]         fwd_sum;
  logic [CNT_W-1:0]    rd_cnt;
  logic                rd_last;
  logic                end_hit;
  logic                accept;

  assign mode_in = mode_t'(i_mode);
  assign rev_m1  = ptr - PW'(1);
  assign fwd_sum = {1'b0, ptr} + (PW+1)'(step_q) + (PW+1)'(1);
  assign rd_last = (rd_cnt == CNT_W'(RD_WAIT - 1));
  assign accept  = (state == S_IDLE) && i_start && !i_clear;

  always_comb begin
    end_hit = 1'b1;
    unique case (mode_in)
      M_REC:   end_hit = ptr[ADDR_W];          // ptr == 2^ADDR_W
      M_FWD:   end_hit = (ptr >= len);
      M_REV:   end_hit = (ptr == '0);
      default: end_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (i_start) state_n = end_hit ? S_FIN : ((mode_in == M_REC) ? S_WR : S_RD);
      S_WR:    state_n = S_DONE;
      S_RD:    if (rd_last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (i_clear) state_n = S_IDLE;
  end

  always_comb begin
    ptr_n = ptr;
    len_n = len;
    if (i_clear) begin
      ptr_n = (mode_in == M_REV) ? len : '0;
      if (mode_in == M_REC) len_n = '0;
    end else if (state == S_DONE) begin
      unique case (mode_q)
        M_REC: begin
          ptr_n = ptr + PW'(1);
          len_n = ptr + PW'(1);
        end
        M_FWD:   ptr_n = (fwd_sum > {1'b0, len}) ? len : fwd_sum[PW-1:0];
        M_REV:   ptr_n = (rev_m1 >= PW'(step_q)) ? (rev_m1 - PW'(step_q)) : '0;
        default: ptr_n = ptr;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      len     <= '0;
      r_data  <= '0;
      mode_q  <= M_FWD;
      step_q  <= '0;
      wdata_q <= '0;
      rd_cnt  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      len    <= len_n;
      rd_cnt <= (state == S_RD) ? rd_cnt + CNT_W'(1) : '0;
      if (accept) begin
        mode_q  <= mode_in;
        step_q  <= i_step;
        wdata_q <= i_w_data;
      end
      // a clear on the sampling cycle aborts the read, so o_r_data is kept
      if ((state == S_RD) && rd_last && !i_clear) r_data <= io_SRAM_DQ;
    end
  end

  assign o_busy      = (state == S_WR) || (state == S_RD) || (state == S_FIN);
  assign o_valid     = (state == S_DONE);
  assign o_fin       = (state == S_FIN);
  assign o_r_data    = r_data;
  assign o_length    = len;
  assign o_SRAM_ADDR = (mode_q == M_REV) ? rev_m1[ADDR_W-1:0] : ptr[ADDR_W-1:0];
  assign io_SRAM_DQ  = (state == S_WR) ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_WE_N = (state != S_WR);
  assign o_SRAM_OE_N = (state == S_WR);
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;

endmodule

// File: tb/tb_sram_stream_ctrl.sv
module tb_sram_stream_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned SW    = 3;
  localparam int unsigned RW    = 2;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clear, start;
  logic [1:0]    mode;
  logic [SW-1:0] step;
  logic [DW-1:0] wdata;
  logic          busy, valid, fin;
  logic [DW-1:0] rdata;
  logic [AW:0]   length;
  logic [AW-1:0] addr;
  wire  [DW-1:0] dq;
  logic          we_n, oe_n, ce_n, lb_n, ub_n;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            m_ptr, m_len;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata;

  // SRAM device model
  logic [DW-1:0] sram [DEPTH];
  assign dq = (!oe_n && we_n) ? sram[addr] : {DW{1'bz}};
  always @(posedge clk) if (!we_n) sram[addr] <= dq;

  always #5 clk = ~clk;

  sram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STEP_W(SW), .RD_WAIT(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_mode(mode), .i_step(step),
    .i_start(start), .i_w_data(wdata), .o_busy(busy), .o_valid(valid), .o_fin(fin),
    .o_r_data(rdata), .o_length(length), .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_OE_N(oe_n), .o_SRAM_CE_N(ce_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_ptr = 0; m_len = 0; m_rdata = '0;
  endtask

  task automatic model_clear(input logic [1:0] md);
    m_ptr = (md == 2'd2) ? m_len : 0;
    if (md == 2'd1) m_len = 0;
  endtask

  task automatic model_access(input logic [1:0] md, input int st, input logic [DW-1:0] wd,
                              output bit efin, output int eaddr);
    efin = 1'b0; eaddr = 0;
    case (md)
      2'd1: if (m_ptr == DEPTH) efin = 1'b1;
            else begin m_mem[m_ptr] = wd; eaddr = m_ptr; m_ptr = m_ptr + 1; m_len = m_ptr; end
      2'd0: if (m_ptr >= m_len) efin = 1'b1;
            else begin
              eaddr = m_ptr; m_rdata = m_mem[eaddr];
              m_ptr = (m_ptr + 1 + st > m_len) ? m_len : m_ptr + 1 + st;
            end
      2'd2: if (m_ptr == 0) efin = 1'b1;
            else begin
              eaddr = m_ptr - 1; m_rdata = m_mem[eaddr];
              m_ptr = (m_ptr - 1 >= st) ? m_ptr - 1 - st : 0;
            end
      default: efin = 1'b1;
    endcase
  endtask

  task automatic do_clear(input logic [1:0] md);
    clear = 1'b1; mode = md; tick; clear = 1'b0;
    model_clear(md);
  endtask

  // Issues one request, then observes 8 cycles (window 0 = cycle after acceptance).
  // With spam set, i_start is held high whenever o_busy is high.
  task automatic run_access(input logic [1:0] md, input int st, input logic [DW-1:0] wd,
                            input bit spam, output int c_valid, output int c_fin,
                            output int n_valid, output int n_fin, output int n_we,
                            output int n_both, output logic [DW-1:0] dq_wr,
                            output logic [AW-1:0] a_launch);
    mode = md; step = SW'(st); wdata = wd; start = 1'b1;
    tick;
    start = 1'b0;
    c_valid = -1; c_fin = -1; n_valid = 0; n_fin = 0; n_we = 0; n_both = 0;
    dq_wr = '0; a_launch = addr;
    for (int c = 0; c < 8; c++) begin
      if (valid) begin n_valid++; if (c_valid < 0) c_valid = c; end
      if (fin)   begin n_fin++;   if (c_fin < 0)   c_fin = c;   end
      if (valid && fin) n_both++;
      if (!we_n) begin n_we++; dq_wr = dq; end
      start = spam && busy;
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; start = 1'b0; mode = 2'd0; step = '0; wdata = '0;
    tick; tick;
    rst = 1'b0;
    model_reset;
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_checks++; if (fin !== 1'b0)    begin n_fail++; $display("FAIL reset_fin: got %0b want 0", fin); end
    n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
    n_checks++; if (length !== 5'd0) begin n_fail++; $display("FAIL reset_length: got %0d want 0", length); end
    n_checks++; if (addr !== 4'd0)   begin n_fail++; $display("FAIL reset_addr: got %0h want 0", addr); end
    n_checks++; if (we_n !== 1'b1 || oe_n !== 1'b0)
      begin n_fail++; $display("FAIL reset_strobes: got we_n=%0b oe_n=%0b want 1/0", we_n, oe_n); end
    n_checks++; if ({ce_n, lb_n, ub_n} !== 3'b000)
      begin n_fail++; $display("FAIL reset_ties: got %b want 000", {ce_n, lb_n, ub_n}); end
  endtask

  task automatic test_record;
    int cv, cf, nv, nf, nw, nb, ea; bit ef; logic [DW-1:0] dw; logic [AW-1:0] al;
    do_clear(2'd1);
    for (int i = 0; i < 5; i++) begin
      model_access(2'd1, 0, DW'(16'hA000 + i), ef, ea);
      run_access(2'd1, 0, DW'(16'hA000 + i), 1'b0, cv, cf, nv, nf, nw, nb, dw, al);
      n_checks++; if (nv != 1 || cv != 1) begin n_fail++; $display("FAIL rec_valid[%0d]: got count=%0d at=%0d want 1 at 1", i, nv, cv); end
      n_checks++; if (nf != 0) begin n_fail++; $display("FAIL rec_fin[%0d]: got %0d want 0", i, nf); end
      n_checks++; if (nw != 1) begin n_fail++; $display("FAIL rec_we_cycles[%0d]: got %0d want 1", i, nw); end
      n_checks++; if (dw !== DW'(16'hA000 + i)) begin n_fail++; $display("FAIL rec_dq[%0d]: got %0h want %0h", i, dw, 16'hA000 + i); end
    end
    n_checks++; if (length !== 5'(m_len)) begin n_fail++; $display("FAIL rec_length: got %0d want %0d", length, m_len); end
  endtask

  task automatic test_play(input logic [1:0] md, input int st, input int n);
    int cv, cf, nv, nf, nw, nb, ea; bit ef; logic [DW-1:0] dw; logic [AW-1:0] al;
    do_clear(md);
    for (int i = 0; i < n; i++) begin
      model_access(md, st, '0, ef, ea);
      run_access(md, st, '0, 1'b0, cv, cf, nv, nf, nw, nb, dw, al);
      if (ef) begin
        n_checks++; if (nf != 1 || cf != 0 || nv != 0)
          begin n_fail++; $display("FAIL play_refuse m%0d[%0d]: got fin=%0d at=%0d valid=%0d want 1 at 0, 0", md, i, nf, cf, nv); end
      end else begin
        n_checks++; if (nv != 1 || cv != RW || nf != 0)
          begin n_fail++; $display("FAIL play_valid m%0d[%0d]: got count=%0d at=%0d fin=%0d want 1 at %0d, 0", md, i, nv, cv, nf, RW); end
        n_checks++; if (al !== AW'(ea)) begin n_fail++; $display("FAIL play_addr m%0d[%0d]: got %0d want %0d", md, i, al, ea); end
        n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL play_rdata m%0d[%0d]: got %0h want %0h", md, i, rdata, m_rdata); end
      end
    end
    n_checks++; if (length !== 5'(m_len)) begin n_fail++; $display("FAIL play_length m%0d: got %0d want %0d", md, length, m_len); end
    if (md == 2'd0) begin
      n_checks++; if (addr !== AW'(m_ptr)) begin n_fail++; $display("FAIL play_ptr m%0d: got %0d want %0d", md, addr, m_ptr); end
    end
  endtask

  task automatic test_full;
    int cv, cf, nv, nf, nw, nb, ea; bit ef; logic [DW-1:0] dw, wd; logic [AW-1:0] al;
    int tot_valid = 0;
    do_clear(2'd1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      wd = DW'($urandom);
      model_access(2'd1, 0, wd, ef, ea);
      run_access(2'd1, int'($urandom_range(0, 7)), wd, 1'b1, cv, cf, nv, nf, nw, nb, dw, al);
      tot_valid += nv;
      if (ef) begin
        n_checks++; if (nf != 1 || nv != 0 || nw != 0)
          begin n_fail++; $display("FAIL full_refuse: got fin=%0d valid=%0d we=%0d want 1,0,0", nf, nv, nw); end
      end
    end
    n_checks++; if (tot_valid != DEPTH) begin n_fail++; $display("FAIL full_valid_count: got %0d want %0d", tot_valid, DEPTH); end
    n_checks++; if (length !== 5'(m_len)) begin n_fail++; $display("FAIL full_length: got %0d want %0d", length, m_len); end
  endtask

  task automatic test_clear_abort;
    int nv = 0;
    do_clear(2'd0);
    mode = 2'd0; step = '0; start = 1'b1;
    tick;
    start = 1'b0;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    model_clear(2'd0);
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0 || fin !== 1'b0 || we_n !== 1'b1)
      begin n_fail++; $display("FAIL abort_outputs: got busy=%0b valid=%0b fin=%0b we_n=%0b want 0,0,0,1", busy, valid, fin, we_n); end
    n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL abort_rdata: got %0h want %0h", rdata, m_rdata); end
    for (int c = 0; c < 4; c++) begin if (valid) nv++; tick; end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL abort_late_valid: got %0d want 0", nv); end
  endtask

  task automatic test_random;
    int cv, cf, nv, nf, nw, nb, ea, st; bit ef, sp; logic [DW-1:0] dw, wd; logic [AW-1:0] al; logic [1:0] md;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear(2'($urandom_range(0, 2)));
      end else begin
        md = 2'($urandom_range(0, 3)); st = int'($urandom_range(0, 7));
        wd = DW'($urandom); sp = 1'($urandom_range(0, 1));
        model_access(md, st, wd, ef, ea);
        run_access(md, st, wd, sp, cv, cf, nv, nf, nw, nb, dw, al);
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL rnd_overlap[%0d]: got %0d want 0", i, nb); end
        if (ef) begin
          n_checks++; if (nf != 1 || cf != 0 || nv != 0)
            begin n_fail++; $display("FAIL rnd_refuse[%0d] m%0d: got fin=%0d at=%0d valid=%0d want 1 at 0, 0", i, md, nf, cf, nv); end
        end else if (md == 2'd1) begin
          n_checks++; if (nv != 1 || cv != 1 || nw != 1 || dw !== wd)
            begin n_fail++; $display("FAIL rnd_rec[%0d]: got valid=%0d at=%0d we=%0d dq=%0h want 1 at 1, 1, %0h", i, nv, cv, nw, dw, wd); end
        end else begin
          n_checks++; if (nv != 1 || cv != RW || al !== AW'(ea) || rdata !== m_rdata)
            begin n_fail++; $display("FAIL rnd_play[%0d] m%0d: got valid=%0d at=%0d addr=%0d data=%0h want 1 at %0d, %0d, %0h", i, md, nv, cv, al, rdata, RW, ea, m_rdata); end
        end
        n_checks++; if (length !== 5'(m_len)) begin n_fail++; $display("FAIL rnd_length[%0d]: got %0d want %0d", i, length, m_len); end
      end
    end
  endtask

  task automatic test_reset_wr;
    int nv = 0;
    do_clear(2'd1);
    mode = 2'd1; wdata = 16'h5A5A; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (we_n !== 1'b0) begin n_fail++; $display("FAIL rstwr_in_write: got we_n=%0b want 0", we_n); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset;
    n_checks++; if (we_n !== 1'b1 || valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL rstwr_outputs: got we_n=%0b valid=%0b busy=%0b want 1,0,0", we_n, valid, busy); end
    n_checks++; if (rdata !== m_rdata || length !== 5'(m_len))
      begin n_fail++; $display("FAIL rstwr_regs: got rdata=%0h len=%0d want %0h, %0d", rdata, length, m_rdata, m_len); end
    for (int c = 0; c < 3; c++) begin if (valid) nv++; tick; end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL rstwr_late_valid: got %0d want 0", nv); end
  endtask

  initial begin
    test_reset;
    test_record;
    test_play(2'd0, 0, 6);
    test_play(2'd0, 2, 3);
    test_play(2'd2, 1, 4);
    test_full;
    test_clear_abort;
    test_play(2'd0, 0, 2);
    test_random;
    test_reset_wr;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
